// File: rtl/pattern_history_predictor.sv
// rtl/pattern_history_predictor.sv - gshare pattern history table with in-order resolve queue
//
// Optional feature macro: PRED_STATS_EN (adds stat_preds / stat_mispreds counters)
//
// Ports:
//   clk             rising-edge clock
//   reset           asynchronous active-high reset
//   bhr_in          [M]        branch history, sampled on request accept
//   req_valid       prediction request
//   req_pc          [PC_BITS]  branch PC, low M bits hashed with bhr_in
//   req_ready       queue not full
//   pred_valid      registered one-cycle prediction pulse
//   pred_taken      predicted direction (valid with pred_valid)
//   pred_index      [M]        table index used (valid with pred_valid)
//   res_valid       resolution of the oldest in-flight branch
//   res_taken       actual outcome (valid with res_valid)
//   mispredict      registered one-cycle pulse on wrong prediction
//   inflight_count  [$clog2(DEPTH+1)] unresolved predictions
//   stat_preds      [16] saturating accepted-request count (PRED_STATS_EN only)
//   stat_mispreds   [16] saturating mispredict count (PRED_STATS_EN only)

module pattern_history_predictor #(
  parameter int M       = 4,
  parameter int PC_BITS = 8,
  parameter int DEPTH   = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [M-1:0]               bhr_in,
  input  logic                       req_valid,
  input  logic [PC_BITS-1:0]         req_pc,
  output logic                       req_ready,
  output logic                       pred_valid,
  output logic                       pred_taken,
  output logic [M-1:0]               pred_index,
  input  logic                       res_valid,
  input  logic                       res_taken,
  output logic                       mispredict,
  output logic [$clog2(DEPTH+1)-1:0] inflight_count
`ifdef PRED_STATS_EN
  ,
  output logic [15:0]                stat_preds,
  output logic [15:0]                stat_mispreds
`endif
);

  localparam int TS = 1 << M;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  // Counter table
  logic [1:0]    ctr_q [TS];
  logic [1:0]    ctr_d [TS];

  // Queue storage and bookkeeping
  logic [M-1:0]  q_idx_q  [DEPTH];
  logic          q_pred_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;

  // Registered outputs
  logic          pred_valid_q, pred_valid_d;
  logic          pred_taken_q, pred_taken_d;
  logic [M-1:0]  pred_index_q, pred_index_d;
  logic          mispredict_q, mispredict_d;

  logic [M-1:0]  idx;
  logic          accept;
  logic          resolve;
  logic [M-1:0]  head_idx;
  logic          head_pred;

  // Upper PC bits do not take part in the hash.
  generate
    if (PC_BITS > M) begin : g_pc_unused
      logic unused_pc_hi;
      assign unused_pc_hi = ^req_pc[PC_BITS-1:M];
    end
  endgenerate

  assign idx       = req_pc[M-1:0] ^ bhr_in;
  // No bypass: a pop in this cycle does not free a slot for a request in this cycle.
  assign req_ready = (count_q < CW'(DEPTH));
  assign accept    = req_valid && req_ready;
  assign resolve   = res_valid && (count_q != '0);
  assign head_idx  = q_idx_q[rd_ptr_q];
  assign head_pred = q_pred_q[rd_ptr_q];

  always_comb begin
    ctr_d        = ctr_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    pred_valid_d = accept;
    pred_taken_d = pred_taken_q;
    pred_index_d = pred_index_q;
    mispredict_d = 1'b0;

    if (accept) begin
      // Prediction reads ctr_q, so a same-cycle update to the same entry is not seen.
      pred_taken_d = ctr_q[idx][1];
      pred_index_d = idx;
      wr_ptr_d     = wr_ptr_q + PW'(1);
    end

    if (resolve) begin
      rd_ptr_d     = rd_ptr_q + PW'(1);
      mispredict_d = (res_taken != head_pred);
      if (res_taken) begin
        if (ctr_q[head_idx] != 2'b11) begin
          ctr_d[head_idx] = ctr_q[head_idx] + 2'd1;
        end
      end else begin
        if (ctr_q[head_idx] != 2'b00) begin
          ctr_d[head_idx] = ctr_q[head_idx] - 2'd1;
        end
      end
    end

    if (accept && !resolve) begin
      count_d = count_q + CW'(1);
    end else if (!accept && resolve) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < TS; i++) begin
        ctr_q[i] <= 2'b01;
      end
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      pred_valid_q <= 1'b0;
      pred_taken_q <= 1'b0;
      pred_index_q <= '0;
      mispredict_q <= 1'b0;
    end else begin
      ctr_q        <= ctr_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      pred_valid_q <= pred_valid_d;
      pred_taken_q <= pred_taken_d;
      pred_index_q <= pred_index_d;
      mispredict_q <= mispredict_d;
    end
  end

  // Entry payload needs no reset; the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (accept) begin
      q_idx_q[wr_ptr_q]  <= idx;
      q_pred_q[wr_ptr_q] <= ctr_q[idx][1];
    end
  end

  assign pred_valid     = pred_valid_q;
  assign pred_taken     = pred_taken_q;
  assign pred_index     = pred_index_q;
  assign mispredict     = mispredict_q;
  assign inflight_count = count_q;

`ifdef PRED_STATS_EN
  logic [15:0] stat_preds_q, stat_preds_d;
  logic [15:0] stat_mispreds_q, stat_mispreds_d;

  always_comb begin
    stat_preds_d    = stat_preds_q;
    stat_mispreds_d = stat_mispreds_q;
    if (accept && (stat_preds_q != 16'hFFFF)) begin
      stat_preds_d = stat_preds_q + 16'd1;
    end
    if (mispredict_q && (stat_mispreds_q != 16'hFFFF)) begin
      stat_mispreds_d = stat_mispreds_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_preds_q    <= '0;
      stat_mispreds_q <= '0;
    end else begin
      stat_preds_q    <= stat_preds_d;
      stat_mispreds_q <= stat_mispreds_d;
    end
  end

  assign stat_preds    = stat_preds_q;
  assign stat_mispreds = stat_mispreds_q;
`endif

endmodule

// File: tb/tb_pattern_history_predictor.sv
// tb/tb_pattern_history_predictor.sv - self-checking bench for pattern_history_predictor

module tb_pattern_history_predictor;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] bhr_in;
  logic       req_valid;
  logic [7:0] req_pc;
  logic       req_ready;
  logic       pred_valid;
  logic       pred_taken;
  logic [3:0] pred_index;
  logic       res_valid;
  logic       res_taken;
  logic       mispredict;
  logic [2:0] inflight_count;

  int errors = 0;
  int checks = 0;

  // Reference model: plain integer counters and a FIFO of pending predictions.
  typedef struct {
    int idx;
    int pred;
  } ent_t;

  int   mctr [16];
  ent_t mq [$];

  pattern_history_predictor #(.M(4), .PC_BITS(8), .DEPTH(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .bhr_in         (bhr_in),
    .req_valid      (req_valid),
    .req_pc         (req_pc),
    .req_ready      (req_ready),
    .pred_valid     (pred_valid),
    .pred_taken     (pred_taken),
    .pred_index     (pred_index),
    .res_valid      (res_valid),
    .res_taken      (res_taken),
    .mispredict     (mispredict),
    .inflight_count (inflight_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mctr[i] = 1;
    mq.delete();
  endtask

  // One clock of stimulus: drive at negedge, predict from the model, check after posedge.
  task automatic step(input bit v, input logic [7:0] pc, input logic [3:0] bhr,
                      input bit rv, input bit rt);
    bit   exp_ready, acc, res, exp_pt, exp_mp;
    int   idx;
    ent_t e;
    @(negedge clk);
    req_valid = v;
    req_pc    = pc;
    bhr_in    = bhr;
    res_valid = rv;
    res_taken = rt;
    #1;
    exp_ready = (mq.size() < 4);
    check("req_ready", {31'b0, req_ready}, {31'b0, exp_ready});
    acc    = v && exp_ready;
    res    = rv && (mq.size() > 0);
    idx    = (int'(pc) % 16) ^ int'(bhr);
    exp_pt = (mctr[idx] >= 2);
    exp_mp = 1'b0;
    if (res) begin
      e      = mq.pop_front();
      exp_mp = (int'(rt) != e.pred);
      if (rt) mctr[e.idx] = (mctr[e.idx] == 3) ? 3 : mctr[e.idx] + 1;
      else    mctr[e.idx] = (mctr[e.idx] == 0) ? 0 : mctr[e.idx] - 1;
    end
    if (acc) mq.push_back('{idx: idx, pred: int'(exp_pt)});
    @(posedge clk);
    #1;
    check("pred_valid", {31'b0, pred_valid}, {31'b0, acc});
    if (acc) begin
      check("pred_taken", {31'b0, pred_taken}, {31'b0, exp_pt});
      check("pred_index", {28'b0, pred_index}, 32'(idx));
    end
    check("mispredict", {31'b0, mispredict}, {31'b0, exp_mp});
    check("inflight_count", {29'b0, inflight_count}, 32'(mq.size()));
    req_valid = 1'b0;
    res_valid = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    bhr_in    = '0;
    req_valid = 1'b0;
    req_pc    = '0;
    res_valid = 1'b0;
    res_taken = 1'b0;
    model_reset();
    #12;
    check("rst_pred_valid", {31'b0, pred_valid}, 32'd0);
    check("rst_pred_taken", {31'b0, pred_taken}, 32'd0);
    check("rst_pred_index", {28'b0, pred_index}, 32'd0);
    check("rst_mispredict", {31'b0, mispredict}, 32'd0);
    check("rst_count", {29'b0, inflight_count}, 32'd0);
    check("rst_ready", {31'b0, req_ready}, 32'd1);
    @(negedge clk);
    reset = 1'b0;

    // First prediction, then a taken resolve that mispredicts.
    step(1, 8'h03, 4'h0, 0, 0);
    step(0, 8'h00, 4'h0, 1, 1);
    step(1, 8'h03, 4'h0, 0, 0);
    step(0, 8'h00, 4'h0, 1, 1);

    // Saturation at index 3.
    for (int i = 0; i < 4; i++) step(1, 8'h03, 4'h0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 8'h00, 4'h0, 1, 1);
    step(1, 8'h03, 4'h0, 0, 0);
    step(0, 8'h00, 4'h0, 1, 0);
    step(1, 8'h03, 4'h0, 0, 0);
    step(0, 8'h00, 4'h0, 1, 1);

    // Aliasing onto index 3.
    step(1, 8'h05, 4'h6, 0, 0);
    step(1, 8'h00, 4'h3, 0, 0);
    step(0, 8'h00, 4'h0, 1, 0);
    step(0, 8'h00, 4'h0, 1, 0);

    // Fill past capacity, then drain and resolve on an empty queue.
    for (int i = 0; i < 5; i++) step(1, 8'(i), 4'h0, 0, 0);
    step(1, 8'h07, 4'h0, 1, 1);
    for (int i = 0; i < 4; i++) step(0, 8'h00, 4'h0, 1, 0);
    step(0, 8'h00, 4'h0, 1, 1);
    step(0, 8'h00, 4'h0, 1, 0);

    // Same-cycle request and resolve on index 3.
    step(1, 8'h03, 4'h0, 0, 0);
    step(1, 8'h03, 4'h0, 1, 0);
    step(1, 8'h13, 4'h0, 1, 1);
    step(0, 8'h00, 4'h0, 1, 1);

    // Asynchronous reset with three entries in flight.
    step(0, 8'h00, 4'h0, 0, 0);
    step(0, 8'h00, 4'h0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 8'h03, 4'h0, 0, 0);
    #2;
    reset = 1'b1;
    #1;
    check("midrst_count", {29'b0, inflight_count}, 32'd0);
    check("midrst_ready", {31'b0, req_ready}, 32'd1);
    check("midrst_pred_valid", {31'b0, pred_valid}, 32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    // Counters back to weakly not-taken: one taken resolve flips index 3 to taken.
    step(1, 8'h03, 4'h0, 0, 0);
    step(0, 8'h00, 4'h0, 1, 1);
    step(1, 8'h03, 4'h0, 0, 0);
    step(1, 8'h0A, 4'h0, 1, 0);
    step(0, 8'h00, 4'h0, 1, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 99) < 60, 8'($urandom), 4'($urandom),
           $urandom_range(0, 99) < 45, 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
